flow_result_checker: RTL and testbench
======================================

Name: flow_result_checker

Overview:
- Clocked stage directly downstream of device_flow. Consumes device_flow's `result` alongside the four operands that produced it.
- Computes the expected sum independently, compares it against `result`, counts mismatches over a fixed-length run and reports pass/fail.
- Replaces open-loop stimulus with a self-checking consumer of the flow datapath.

Parameters:
- numberOfBits, 8, width of every operand, of `result`, and of the counters.
- numberOfSamples, 10, samples per run; legal range 1 to 2^numberOfBits-1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run.
- sampleValid  input  1  operands and result are valid this cycle.
- leftAdderLeftInput  input  numberOfBits  operand A, as driven into device_flow.
- leftAdderRightInput  input  numberOfBits  operand B.
- rightAdderLeftInput  input  numberOfBits  operand C.
- rightAdderRightInput  input  numberOfBits  operand D.
- result  input  numberOfBits  device_flow output for A..D.
- busy  output  1  run in progress.
- done  output  1  run complete; held until the next start or reset.
- pass  output  1  valid while done=1; 1 = zero mismatches.
- errorCount  output  numberOfBits  number of mismatches.
- sampleCount  output  numberOfBits  number of samples accepted.
- firstErrorIndex  output  numberOfBits  sampleCount value of the first mismatching sample.
- firstErrorValue  output  numberOfBits  `result` value of the first mismatching sample.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - State goes to IDLE.
  - All outputs go to 0.
  - The stage-1 valid flag is cleared.
  - Reset has priority over every other input, including mid-run; no partial results survive it.
- Expected value: A+B+C+D, truncated to numberOfBits (modulo 2^numberOfBits). This matches device_flow's defined function. Carries beyond numberOfBits are discarded, never flagged.
- Two-stage pipeline:
  - Stage 1 (accept): on an edge with state RUN and sampleValid=1, register A, B, C, D and result, set the stage-1 valid flag, and increment sampleCount.
  - Stage 2 (compare): on the following edge, if the stage-1 valid flag is set, compare the truncated sum against the registered result.
  - Latency from a sample's accept edge to its errorCount update is 1 clock.
- On a mismatch:
  - errorCount increments and saturates at all-ones.
  - If this is the first mismatch of the run, capture firstErrorIndex (0-based index of that sample) and firstErrorValue (its `result`).
- States:
  - IDLE: busy=0, done=0. start=1 moves to RUN. On that edge, clear errorCount, sampleCount, firstErrorIndex and firstErrorValue, and set busy=1.
  - RUN: accept samples as above. sampleValid=0 cycles are gaps with no effect. After numberOfSamples samples are accepted, no further samples are accepted. On the edge that compares the last sample, move to DONE: busy=0, done=1, pass = (errorCount after that compare == 0).
  - DONE: outputs hold. start=1 restarts the run exactly as from IDLE, including clearing done and pass on the same edge.
- start while in RUN: ignored.
- sampleValid while in IDLE or DONE: ignored; counters do not change.
- sampleValid on the same edge as the IDLE→RUN start: not accepted. The first acceptable sample is on the next edge.
- Back-to-back sampleValid (one per clock): full throughput, no stalls. The compare of sample k overlaps the accept of sample k+1.
- pass is 0 whenever done is 0.

Test Plan:
- Reset, start, then 10 consecutive samples with all four operands = i and result = 4i (i = 0..9) → done=1 one clock after the 10th accept; pass=1, errorCount=0, sampleCount=10.
- Same as the first scenario, but sample 3 has result=0x0D instead of 0x0C, and sample 7 has result=0x00 instead of 0x1C → errorCount=2, firstErrorIndex=3, firstErrorValue=0x0D, pass=0.
- Overflow: operands 0x40,0x40,0x40,0x40 with result 0x00, and operands 0xFF,0x01,0x00,0x00 with result 0x00 → both samples match; errorCount=0.
- Gaps and ignored inputs:
  - Sample stream with sampleValid low every other cycle → same final results as the first scenario.
  - sampleValid pulses while in IDLE → sampleCount stays 0.
  - start pulse mid-run → no effect.
- Reset asserted after 5 accepted samples, one of which mismatched → next edge gives busy=0, done=0, errorCount=0, sampleCount=0. A fresh start then completes normally with pass=1.
- Restart from DONE with a failed prior run → start clears done, pass and all counters on the same edge. Then 10 correct samples → pass=1.

Source files
------------

// File: rtl/flow_result_checker.sv
// +----------------------------------------------------------------------------+
// | flow_result_checker                                                        |
// | Self-checking consumer of device_flow: recomputes A+B+C+D, counts result   |
// | mismatches over a fixed-length run and reports pass/fail.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module flow_result_checker #(
    parameter int numberOfBits    = 8,
    parameter int numberOfSamples = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    sampleValid,
    input  logic [numberOfBits-1:0] leftAdderLeftInput,
    input  logic [numberOfBits-1:0] leftAdderRightInput,
    input  logic [numberOfBits-1:0] rightAdderLeftInput,
    input  logic [numberOfBits-1:0] rightAdderRightInput,
    input  logic [numberOfBits-1:0] result,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [numberOfBits-1:0] errorCount,
    output logic [numberOfBits-1:0] sampleCount,
    output logic [numberOfBits-1:0] firstErrorIndex,
    output logic [numberOfBits-1:0] firstErrorValue
);

    localparam logic [numberOfBits-1:0] c_NUM_SAMPLES = numberOfBits'(numberOfSamples);
    localparam logic [numberOfBits-1:0] c_LAST_INDEX  = numberOfBits'(numberOfSamples - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [numberOfBits-1:0] r_errorCount;
    logic [numberOfBits-1:0] r_sampleCount;
    logic [numberOfBits-1:0] r_firstErrorIndex;
    logic [numberOfBits-1:0] r_firstErrorValue;

    // Stage-1 registers: one accepted sample awaiting its compare.
    logic                    r_s1Valid;
    logic                    r_s1Last;
    logic [numberOfBits-1:0] r_s1Index;
    logic [numberOfBits-1:0] r_a;
    logic [numberOfBits-1:0] r_b;
    logic [numberOfBits-1:0] r_c;
    logic [numberOfBits-1:0] r_d;
    logic [numberOfBits-1:0] r_result;

    logic                    w_accept;
    logic [numberOfBits-1:0] w_sum;
    logic                    w_mismatch;
    logic [numberOfBits-1:0] w_errorNext;

    assign w_accept    = (r_state == S_RUN) && sampleValid && (r_sampleCount < c_NUM_SAMPLES);
    assign w_sum       = r_a + r_b + r_c + r_d;
    assign w_mismatch  = r_s1Valid && (w_sum != r_result);
    assign w_errorNext = (w_mismatch && (r_errorCount != '1)) ? r_errorCount + 1'b1 : r_errorCount;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_errorCount      <= '0;
            r_sampleCount     <= '0;
            r_firstErrorIndex <= '0;
            r_firstErrorValue <= '0;
            r_s1Valid         <= 1'b0;
            r_s1Last          <= 1'b0;
            r_s1Index         <= '0;
            r_a               <= '0;
            r_b               <= '0;
            r_c               <= '0;
            r_d               <= '0;
            r_result          <= '0;
        end else begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_a           <= leftAdderLeftInput;
                r_b           <= leftAdderRightInput;
                r_c           <= rightAdderLeftInput;
                r_d           <= rightAdderRightInput;
                r_result      <= result;
                r_s1Index     <= r_sampleCount;
                r_s1Last      <= (r_sampleCount == c_LAST_INDEX);
                r_sampleCount <= r_sampleCount + 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state           <= S_RUN;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                        r_errorCount      <= '0;
                        r_sampleCount     <= '0;
                        r_firstErrorIndex <= '0;
                        r_firstErrorValue <= '0;
                    end
                end
                S_RUN: begin
                    if (r_s1Valid) begin
                        r_errorCount <= w_errorNext;
                        // The counter saturates rather than wraps, so zero means no earlier mismatch.
                        if (w_mismatch && (r_errorCount == '0)) begin
                            r_firstErrorIndex <= r_s1Index;
                            r_firstErrorValue <= r_result;
                        end
                        if (r_s1Last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_errorNext == '0);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign errorCount      = r_errorCount;
    assign sampleCount     = r_sampleCount;
    assign firstErrorIndex = r_firstErrorIndex;
    assign firstErrorValue = r_firstErrorValue;

endmodule

`default_nettype wire

// File: tb/tb_flow_result_checker.sv
// +----------------------------------------------------------------------------+
// | tb_flow_result_checker                                                     |
// | Directed scenarios plus random traffic against a behavioural model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_flow_result_checker;

    localparam int NB = 8;
    localparam int NS = 10;

    logic          clock = 1'b0;
    logic          reset, start, sampleValid;
    logic [NB-1:0] a, b, c, d, res;
    logic          busy, done, pass;
    logic [NB-1:0] errorCount, sampleCount, firstErrorIndex, firstErrorValue;

    flow_result_checker #(.numberOfBits(NB), .numberOfSamples(NS)) dut (
        .clock                (clock),
        .reset                (reset),
        .start                (start),
        .sampleValid          (sampleValid),
        .leftAdderLeftInput   (a),
        .leftAdderRightInput  (b),
        .rightAdderLeftInput  (c),
        .rightAdderRightInput (d),
        .result               (res),
        .busy                 (busy),
        .done                 (done),
        .pass                 (pass),
        .errorCount           (errorCount),
        .sampleCount          (sampleCount),
        .firstErrorIndex      (firstErrorIndex),
        .firstErrorValue      (firstErrorValue)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: run status plus the sample whose verdict lands on the next edge.
    bit m_busy, m_done, m_pass;
    int m_err, m_cnt, m_fidx, m_fval;
    bit p_valid;
    int p_idx, p_sum, p_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit o_busy;
        int o_cnt;
        o_busy = m_busy;
        o_cnt  = m_cnt;
        if (reset) begin
            m_busy = 0; m_done = 0; m_pass = 0;
            m_err = 0; m_cnt = 0; m_fidx = 0; m_fval = 0;
            p_valid = 0;
            return;
        end
        if (p_valid) begin
            if (p_sum != p_res) begin
                if (m_err == 0) begin
                    m_fidx = p_idx;
                    m_fval = p_res;
                end
                if (m_err < 255) m_err++;
            end
            if (p_idx == NS - 1) begin
                m_busy = 0; m_done = 1; m_pass = (m_err == 0);
            end
        end
        p_valid = 0;
        if (o_busy && sampleValid && o_cnt < NS) begin
            p_valid = 1;
            p_idx   = o_cnt;
            p_sum   = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
            p_res   = int'(res);
            m_cnt   = o_cnt + 1;
        end
        if (!o_busy && start) begin
            m_busy = 1; m_done = 0; m_pass = 0;
            m_err = 0; m_cnt = 0; m_fidx = 0; m_fval = 0;
        end
    endtask

    task automatic check_all();
        check("busy",            busy,            m_busy);
        check("done",            done,            m_done);
        check("pass",            pass,            m_pass);
        check("errorCount",      errorCount,      m_err);
        check("sampleCount",     sampleCount,     m_cnt);
        check("firstErrorIndex", firstErrorIndex, m_fidx);
        check("firstErrorValue", firstErrorValue, m_fval);
    endtask

    task automatic step(input logic rst, input logic st, input logic v,
                        input logic [NB-1:0] ia, input logic [NB-1:0] ib,
                        input logic [NB-1:0] ic, input logic [NB-1:0] id,
                        input logic [NB-1:0] ir);
        reset = rst; start = st; sampleValid = v;
        a = ia; b = ib; c = ic; d = id; res = ir;
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic good_sample(input logic [NB-1:0] i);
        step(0, 0, 1, i, i, i, i, 8'(4 * i));
    endtask

    initial begin
        logic [NB-1:0] ra, rb, rc, rd, rr;

        // Reset state, then valid pulses in IDLE are ignored.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(i), 8'(i), 8'(i), 8'(i), 8'(4 * i));
        check("idle_sampleCount", sampleCount, 0);

        // Clean run; the start edge also carries a valid that must not be accepted.
        step(0, 1, 1, 1, 1, 1, 1, 4);
        for (int i = 0; i < NS; i++) good_sample(8'(i));
        idle_cycle();
        check("run1_done", done, 1);
        check("run1_pass", pass, 1);
        check("run1_cnt", sampleCount, 10);
        idle_cycle();

        // Mismatches on samples 3 and 7.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NS; i++) begin
            rr = (i == 3) ? 8'h0D : (i == 7) ? 8'h00 : 8'(4 * i);
            step(0, 0, 1, 8'(i), 8'(i), 8'(i), 8'(i), rr);
        end
        idle_cycle();
        check("run2_err", errorCount, 2);
        check("run2_fidx", firstErrorIndex, 3);
        check("run2_fval", firstErrorValue, 8'h0D);
        check("run2_pass", pass, 0);

        // Restart from a failed run; overflowing sums wrap and still match.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("restart_done", done, 0);
        check("restart_err", errorCount, 0);
        step(0, 0, 1, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00);
        step(0, 0, 1, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00);
        for (int i = 2; i < NS; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            step(0, 0, 1, ra, rb, rc, rd, 8'(ra + rb + rc + rd));
        end
        idle_cycle();
        check("run3_err", errorCount, 0);
        check("run3_pass", pass, 1);

        // Gapped stream with a start pulse mid-run.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NS; i++) begin
            if (i == 4) step(0, 1, 1, 8'(i), 8'(i), 8'(i), 8'(i), 8'(4 * i));
            else        good_sample(8'(i));
            idle_cycle();
        end
        check("gap_pass", pass, 1);
        check("gap_cnt", sampleCount, 10);

        // Reset mid-run after five samples, one of them wrong.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 8'(i), 8'(i), 8'(i), 8'(i), (i == 2) ? 8'h55 : 8'(4 * i));
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_busy", busy, 0);
        check("rst_err", errorCount, 0);
        check("rst_cnt", sampleCount, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NS; i++) good_sample(8'(i));
        idle_cycle();
        check("after_rst_pass", pass, 1);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            rr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(ra + rb + rc + rd);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), ra, rb, rc, rd, rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
